// File: rtl/register_file_pkg.sv
// Shared parameters and helpers for the register file slice.
// Source/destination index NREGS is the data-IO pseudo register.
package regfile_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int X0        = 0;

   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int data_io_idx(input int nregs);
      return nregs;
   endfunction
endpackage

// File: rtl/register_file_if.sv
// Issue/write-back/move/read/IO bundle between decode-issue, execute and the register file.
interface register_file_if #(
   parameter int XLEN  = regfile_pkg::XLEN_DEF,
   parameter int NREGS = regfile_pkg::NREGS_DEF,
   parameter int NRD   = 2
) ();
   import regfile_pkg::*;
   localparam int RW = idx_w(NREGS);
   localparam int AW = RW + 1;

   logic [NRD*RW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                iss_valid;
   logic [RW-1:0]       iss_rd;
   logic                iss_ready;
   logic                wb_valid;
   logic [RW-1:0]       wb_rd;
   logic [XLEN-1:0]     wb_data;
   logic                mv_valid;
   logic                mv_ready;
   logic [AW-1:0]       mv_src;
   logic [NREGS:0]      mv_dest_msk;
   logic [XLEN-1:0]     mv_data_in;
   logic                io_valid;
   logic                io_ready;
   logic [XLEN-1:0]     io_data;

   modport master (
      output rd_addr, iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
             mv_valid, mv_src, mv_dest_msk, mv_data_in, io_ready,
      input  rd_data, rd_busy, iss_ready, mv_ready, io_valid, io_data
   );

   modport slave (
      input  rd_addr, iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
             mv_valid, mv_src, mv_dest_msk, mv_data_in, io_ready,
      output rd_data, rd_busy, iss_ready, mv_ready, io_valid, io_data
   );
endinterface

// File: rtl/register_file_scoreboard.sv
// Busy scoreboard: issue sets, write-back clears; x0 never busy.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int RW    = idx_w(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             iss_valid_i,
   input  logic [RW-1:0]    iss_rd_i,
   input  logic             wb_valid_i,
   input  logic [RW-1:0]    wb_rd_i,
   output logic [NREGS-1:0] busy_o,
   output logic             iss_ready_o,
   output logic             iss_acc_o
);
   logic [NREGS-1:0] busy_q, busy_d;

   assign iss_ready_o = !busy_q[iss_rd_i] || (wb_valid_i && wb_rd_i == iss_rd_i) ||
                        iss_rd_i == RW'(X0);
   assign iss_acc_o   = iss_valid_i && iss_ready_o;
   assign busy_o      = busy_q;

   // Set after clear so a same-cycle issue and write-back leave the register busy.
   always_comb begin
      busy_d = busy_q;
      if (wb_valid_i) busy_d[wb_rd_i] = 1'b0;
      if (iss_acc_o)  busy_d[iss_rd_i] = 1'b1;
      busy_d[X0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end
endmodule

// File: rtl/register_file.sv
// Register file with busy scoreboard, write-back bypass, broadcast moves and
// a single-entry valid/ready IO output slot.
module register_file
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2
) (
   input  logic          clk,
   input  logic          reset,
   register_file_if.slave bus
);
   localparam int RW      = idx_w(NREGS);
   localparam int AW      = RW + 1;
   localparam int DATA_IO = data_io_idx(NREGS);

   logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
   logic [NREGS-1:0]           busy;
   logic                       iss_acc;
   logic                       io_valid_q, io_valid_d;
   logic [XLEN-1:0]            io_data_q, io_data_d;

   regfile_scoreboard #(.NREGS(NREGS), .RW(RW)) u_sb (
      .clk        (clk),
      .reset      (reset),
      .iss_valid_i(bus.iss_valid),
      .iss_rd_i   (bus.iss_rd),
      .wb_valid_i (bus.wb_valid),
      .wb_rd_i    (bus.wb_rd),
      .busy_o     (busy),
      .iss_ready_o(bus.iss_ready),
      .iss_acc_o  (iss_acc)
   );

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [RW-1:0] a;
      logic          byp;
      assign a   = bus.rd_addr[k*RW +: RW];
      assign byp = bus.wb_valid && bus.wb_rd == a && a != RW'(X0);
      assign bus.rd_data[k*XLEN +: XLEN] = (a == RW'(X0)) ? '0 : byp ? bus.wb_data : regs_q[a];
      assign bus.rd_busy[k] = (a != RW'(X0)) && !byp && busy[a];
   end

   logic [RW-1:0]   src_reg;
   logic            src_in_rf, src_byp, mv_acc;
   logic [XLEN-1:0] mv_val;

   assign src_reg   = bus.mv_src[RW-1:0];
   assign src_in_rf = bus.mv_src < AW'(NREGS) && bus.mv_src != AW'(X0);
   assign src_byp   = bus.wb_valid && bus.wb_rd == src_reg;

   always_comb begin
      mv_val = '0;
      if (src_in_rf)                        mv_val = src_byp ? bus.wb_data : regs_q[src_reg];
      else if (bus.mv_src == AW'(DATA_IO))  mv_val = bus.mv_data_in;
   end

   // The issue-hit term stalls the move so the register stays owned by the in-flight op.
   assign bus.mv_ready = !((src_in_rf && busy[src_reg] && !src_byp) ||
                           (|(bus.mv_dest_msk[NREGS-1:0] & busy)) ||
                           (bus.mv_dest_msk[DATA_IO] && io_valid_q && !bus.io_ready) ||
                           (iss_acc && bus.iss_rd != RW'(X0) && bus.mv_dest_msk[bus.iss_rd]));
   assign mv_acc = bus.mv_valid && bus.mv_ready;

   always_comb begin
      regs_d = regs_q;
      for (int r = 1; r < NREGS; r++) begin
         if (mv_acc && bus.mv_dest_msk[r])                regs_d[r] = mv_val;
         else if (bus.wb_valid && bus.wb_rd == RW'(r))    regs_d[r] = bus.wb_data;
      end
      regs_d[X0] = '0;
   end

   always_comb begin
      io_valid_d = io_valid_q;
      io_data_d  = io_data_q;
      if (mv_acc && bus.mv_dest_msk[DATA_IO]) begin
         io_valid_d = 1'b1;
         io_data_d  = mv_val;
      end else if (io_valid_q && bus.io_ready) begin
         io_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q     <= '0;
         io_valid_q <= 1'b0;
         io_data_q  <= '0;
      end else begin
         regs_q     <= regs_d;
         io_valid_q <= io_valid_d;
         io_data_q  <= io_data_d;
      end
   end

   assign bus.io_valid = io_valid_q;
   assign bus.io_data  = io_data_q;
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset/x0, issue and bypass, broadcast moves,
// IO backpressure, write conflicts and asynchronous reset.
module tb_register_file;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int RW    = 5;
   localparam int AW    = 6;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   register_file_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

   register_file #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.rd_addr     = '0;
      bus.iss_valid   = 1'b0;
      bus.iss_rd      = '0;
      bus.wb_valid    = 1'b0;
      bus.wb_rd       = '0;
      bus.wb_data     = '0;
      bus.mv_valid    = 1'b0;
      bus.mv_src      = '0;
      bus.mv_dest_msk = '0;
      bus.mv_data_in  = '0;
      bus.io_ready    = 1'b0;
   endtask

   function automatic logic [XLEN-1:0] rdata(input int k);
      return bus.rd_data[k*XLEN +: XLEN];
   endfunction

   task automatic set_rd(input int k, input int a);
      bus.rd_addr[k*RW +: RW] = RW'(a);
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      step();
      checks++; if (bus.io_valid !== 1'b0) begin failures++; $display("FAIL reset_io_valid got=%b exp=0", bus.io_valid); end
      checks++; if (bus.io_data !== 32'h0) begin failures++; $display("FAIL reset_io_data got=%h exp=0", bus.io_data); end
      checks++; if (bus.iss_ready !== 1'b1) begin failures++; $display("FAIL reset_iss_ready got=%b exp=1", bus.iss_ready); end
      bus.mv_dest_msk = 33'h1_0000_0002;
      #1;
      checks++; if (bus.mv_ready !== 1'b1) begin failures++; $display("FAIL reset_mv_ready got=%b exp=1", bus.mv_ready); end
      bus.mv_dest_msk = '0;
      reset = 1'b0;
      step();
   endtask

   task automatic test_x0();
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
      set_rd(0, 0);
      #1;
      checks++; if (rdata(0) !== 32'h0) begin failures++; $display("FAIL x0_wb_same_cycle got=%h exp=0", rdata(0)); end
      checks++; if (bus.rd_busy[0] !== 1'b0) begin failures++; $display("FAIL x0_busy got=%b exp=0", bus.rd_busy[0]); end
      step();
      idle();
      for (int r = 0; r < NREGS; r++) begin
         set_rd(1, r);
         #1;
         checks++;
         if (rdata(1) !== 32'h0 || bus.rd_busy[1] !== 1'b0) begin
            failures++; $display("FAIL reg_after_reset r=%0d got=%h busy=%b exp=0", r, rdata(1), bus.rd_busy[1]);
         end
      end
   endtask

   task automatic test_issue_bypass();
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
      #1;
      checks++; if (bus.iss_ready !== 1'b1) begin failures++; $display("FAIL issue_x5_ready got=%b exp=1", bus.iss_ready); end
      step();
      idle();
      set_rd(0, 5);
      bus.iss_rd = 5'd5;
      bus.mv_src = AW'(5); bus.mv_dest_msk = 33'h4;
      #1;
      checks++; if (bus.rd_busy[0] !== 1'b1) begin failures++; $display("FAIL x5_busy got=%b exp=1", bus.rd_busy[0]); end
      checks++; if (bus.mv_ready !== 1'b0) begin failures++; $display("FAIL mv_src_busy_ready got=%b exp=0", bus.mv_ready); end
      checks++; if (bus.iss_ready !== 1'b0) begin failures++; $display("FAIL reissue_busy_ready got=%b exp=0", bus.iss_ready); end
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h1234;
      #1;
      checks++; if (rdata(0) !== 32'h1234) begin failures++; $display("FAIL bypass_data got=%h exp=1234", rdata(0)); end
      checks++; if (bus.rd_busy[0] !== 1'b0) begin failures++; $display("FAIL bypass_busy got=%b exp=0", bus.rd_busy[0]); end
      checks++; if (bus.mv_ready !== 1'b1) begin failures++; $display("FAIL mv_src_bypass_ready got=%b exp=1", bus.mv_ready); end
      checks++; if (bus.iss_ready !== 1'b1) begin failures++; $display("FAIL iss_wb_bypass_ready got=%b exp=1", bus.iss_ready); end
      step();
      idle();
      set_rd(1, 5);
      #1;
      checks++; if (rdata(1) !== 32'h1234 || bus.rd_busy[1] !== 1'b0) begin
         failures++; $display("FAIL x5_after_wb got=%h busy=%b exp=1234/0", rdata(1), bus.rd_busy[1]);
      end
   endtask

   task automatic test_broadcast();
      bus.mv_valid = 1'b1; bus.mv_src = AW'(NREGS); bus.mv_data_in = 32'hCAFE;
      bus.mv_dest_msk = 33'h1_0000_0083;
      #1;
      checks++; if (bus.mv_ready !== 1'b1) begin failures++; $display("FAIL bcast_ready got=%b exp=1", bus.mv_ready); end
      step();
      idle();
      set_rd(0, 1); set_rd(1, 7);
      #1;
      checks++; if (rdata(0) !== 32'hCAFE) begin failures++; $display("FAIL bcast_x1 got=%h exp=cafe", rdata(0)); end
      checks++; if (rdata(1) !== 32'hCAFE) begin failures++; $display("FAIL bcast_x7 got=%h exp=cafe", rdata(1)); end
      checks++; if (bus.io_valid !== 1'b1 || bus.io_data !== 32'hCAFE) begin
         failures++; $display("FAIL bcast_io got=%b/%h exp=1/cafe", bus.io_valid, bus.io_data);
      end
      set_rd(0, 0); set_rd(1, 2);
      #1;
      checks++; if (rdata(0) !== 32'h0) begin failures++; $display("FAIL bcast_x0 got=%h exp=0", rdata(0)); end
      checks++; if (rdata(1) !== 32'h0) begin failures++; $display("FAIL bcast_x2_untouched got=%h exp=0", rdata(1)); end
   endtask

   task automatic test_io_backpressure();
      bus.mv_valid = 1'b1; bus.mv_src = AW'(NREGS); bus.mv_data_in = 32'hBEEF;
      bus.mv_dest_msk = 33'h1_0000_0000;
      #1;
      checks++; if (bus.mv_ready !== 1'b0) begin failures++; $display("FAIL io_bp_ready got=%b exp=0", bus.mv_ready); end
      step();
      checks++; if (bus.io_data !== 32'hCAFE || bus.io_valid !== 1'b1) begin
         failures++; $display("FAIL io_bp_hold got=%b/%h exp=1/cafe", bus.io_valid, bus.io_data);
      end
      bus.io_ready = 1'b1;
      #1;
      checks++; if (bus.mv_ready !== 1'b1) begin failures++; $display("FAIL io_release_ready got=%b exp=1", bus.mv_ready); end
      step();
      checks++; if (bus.io_data !== 32'hBEEF || bus.io_valid !== 1'b1) begin
         failures++; $display("FAIL io_replace got=%b/%h exp=1/beef", bus.io_valid, bus.io_data);
      end
      bus.mv_valid = 1'b0;
      step();
      checks++; if (bus.io_valid !== 1'b0) begin failures++; $display("FAIL io_drain got=%b exp=0", bus.io_valid); end
      idle();
   endtask

   task automatic test_back_to_back();
      bus.io_ready = 1'b1;
      bus.mv_valid = 1'b1; bus.mv_src = AW'(NREGS); bus.mv_dest_msk = 33'h1_0000_0000;
      for (int i = 1; i <= 3; i++) begin
         bus.mv_data_in = 32'hA0 + 32'(i);
         #1;
         checks++; if (bus.mv_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, bus.mv_ready); end
         step();
         checks++; if (bus.io_valid !== 1'b1 || bus.io_data !== 32'hA0 + 32'(i)) begin
            failures++; $display("FAIL b2b_io i=%0d got=%b/%h exp=1/%h", i, bus.io_valid, bus.io_data, 32'hA0 + 32'(i));
         end
      end
      bus.mv_valid = 1'b0;
      step();
      idle();
   endtask

   task automatic test_conflicts();
      bus.mv_valid = 1'b1; bus.mv_src = AW'(NREGS); bus.mv_data_in = 32'hAAAA;
      bus.mv_dest_msk = 33'h8;
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h5555;
      step();
      idle();
      set_rd(0, 3);
      #1;
      checks++; if (rdata(0) !== 32'hAAAA) begin failures++; $display("FAIL mv_beats_wb got=%h exp=aaaa", rdata(0)); end
      bus.mv_valid = 1'b1; bus.mv_src = AW'(40); bus.mv_data_in = 32'h7777; bus.mv_dest_msk = 33'h8;
      step();
      bus.mv_valid = 1'b0;
      #1;
      checks++; if (rdata(0) !== 32'h0) begin failures++; $display("FAIL src_out_of_range got=%h exp=0", rdata(0)); end
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
      bus.mv_valid = 1'b1; bus.mv_src = AW'(NREGS); bus.mv_data_in = 32'h99; bus.mv_dest_msk = 33'h200;
      #1;
      checks++; if (bus.iss_ready !== 1'b1) begin failures++; $display("FAIL iss_x9_ready got=%b exp=1", bus.iss_ready); end
      checks++; if (bus.mv_ready !== 1'b0) begin failures++; $display("FAIL iss_mv_hit_ready got=%b exp=0", bus.mv_ready); end
      step();
      idle();
      set_rd(1, 9);
      #1;
      checks++; if (bus.rd_busy[1] !== 1'b1 || rdata(1) !== 32'h0) begin
         failures++; $display("FAIL x9_after_conflict got=%h busy=%b exp=0/1", rdata(1), bus.rd_busy[1]);
      end
   endtask

   task automatic test_async_reset();
      bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
      bus.mv_valid = 1'b1; bus.mv_src = AW'(NREGS); bus.mv_data_in = 32'h22;
      bus.mv_dest_msk = 33'h1_0000_0004;
      step();
      idle();
      set_rd(0, 4); set_rd(1, 2);
      #1;
      checks++; if (bus.rd_busy[0] !== 1'b1 || bus.io_valid !== 1'b1 || rdata(1) !== 32'h22) begin
         failures++; $display("FAIL pre_reset_state got=busy%b/io%b/%h exp=1/1/22", bus.rd_busy[0], bus.io_valid, rdata(1));
      end
      bus.mv_dest_msk = 33'h1_0000_0000;
      bus.iss_rd = 5'd4;
      #1;
      reset = 1'b1;
      #1;
      checks++; if (bus.rd_busy[0] !== 1'b0) begin failures++; $display("FAIL async_busy got=%b exp=0", bus.rd_busy[0]); end
      checks++; if (bus.io_valid !== 1'b0 || bus.io_data !== 32'h0) begin
         failures++; $display("FAIL async_io got=%b/%h exp=0/0", bus.io_valid, bus.io_data);
      end
      checks++; if (rdata(1) !== 32'h0) begin failures++; $display("FAIL async_x2 got=%h exp=0", rdata(1)); end
      checks++; if (bus.iss_ready !== 1'b1 || bus.mv_ready !== 1'b1) begin
         failures++; $display("FAIL async_ready got=iss%b/mv%b exp=1/1", bus.iss_ready, bus.mv_ready);
      end
      step();
      reset = 1'b0;
      idle();
      step();
   endtask

   initial begin
      test_reset();
      test_x0();
      test_issue_bypass();
      test_broadcast();
      test_io_backpressure();
      test_back_to_back();
      test_conflicts();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
